// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int WIDTH_DEF = 7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);
endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_r,
  output logic             o_q
);
  logic [WIDTH:0] w_t;
  logic           w_unused;

  // R never exceeds the divisor on a fitting quotient, so its top bit is dropped by the shift.
  assign w_t      = {i_r[WIDTH-1:0], i_bit};
  assign w_unused = i_r[WIDTH];

  always_comb begin
    o_r = w_t;
    o_q = 1'b0;
    if (w_t >= {1'b0, i_div}) begin
      o_r = w_t - {1'b0, i_div};
      o_q = 1'b1;
    end
  end
endmodule

// File: rtl/div_14_7_seq.sv
// Sequential 2W/W unsigned restoring divider with valid/ready handshakes, one quotient bit per cycle.
// Define DIV_FAST_EXIT_EN to send divide-by-zero and overflow operations straight to DONE.
module div_14_7_seq
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 ovf,
  output logic                 dbz
);
  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_lo;
  logic             r_exc_ovf;
  logic             r_exc_dbz;
  logic [WIDTH-1:0] r_quo_o;
  logic [WIDTH-1:0] r_rem_o;
  logic             r_ovf_o;
  logic             r_dbz_o;

  logic             w_take_in;
  logic             w_last;
  logic             w_dbz_in;
  logic             w_ovf_in;
  logic [WIDTH:0]   w_step_r;
  logic             w_step_q;

  function automatic logic [WIDTH-1:0] sat_quotient();
    return '1;
  endfunction

  function automatic logic [WIDTH-1:0] sat_remainder(input logic is_dbz,
                                                     input logic [WIDTH-1:0] lo);
    return is_dbz ? lo : '0;
  endfunction

  assign w_take_in = (r_state == IDLE) && in_valid;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_dbz_in  = (divisor == '0);
  assign w_ovf_in  = !w_dbz_in && (dividend[2*WIDTH-1:WIDTH] >= divisor);

  assign in_ready  = rst_n && (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quo_o;
  assign remainder = r_rem_o;
  assign ovf       = r_ovf_o;
  assign dbz       = r_dbz_o;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r   (r_rem),
    .i_bit (r_shift[WIDTH-1]),
    .i_div (r_div),
    .o_r   (w_step_r),
    .o_q   (w_step_q)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
`ifdef DIV_FAST_EXIT_EN
          w_state_nxt = (w_dbz_in || w_ovf_in) ? DONE : CALC;
`else
          w_state_nxt = CALC;
`endif
        end
      end
      CALC:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control: state and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take_in)              r_cnt <= '0;
      else if (r_state == CALC)   r_cnt <= r_cnt + CW'(1);
    end
  end

  // Working datapath: operand capture and one restoring step per CALC cycle
  always_ff @(posedge clk) begin
    if (w_take_in) begin
      r_rem     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
      r_shift   <= dividend[WIDTH-1:0];
      r_lo      <= dividend[WIDTH-1:0];
      r_div     <= divisor;
      r_q       <= '0;
      r_exc_dbz <= w_dbz_in;
      r_exc_ovf <= w_ovf_in;
    end else if (r_state == CALC) begin
      r_rem   <= w_step_r;
      r_shift <= r_shift << 1;
      r_q     <= {r_q[WIDTH-2:0], w_step_q};
    end
  end

  // Result registers: loaded only on entry to DONE, held through and after the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo_o <= '0;
      r_rem_o <= '0;
      r_ovf_o <= 1'b0;
      r_dbz_o <= 1'b0;
    end else begin
`ifdef DIV_FAST_EXIT_EN
      if (w_take_in && (w_dbz_in || w_ovf_in)) begin
        r_quo_o <= sat_quotient();
        r_rem_o <= sat_remainder(w_dbz_in, dividend[WIDTH-1:0]);
        r_ovf_o <= w_ovf_in;
        r_dbz_o <= w_dbz_in;
      end
`endif
      if ((r_state == CALC) && w_last) begin
        r_ovf_o <= r_exc_ovf;
        r_dbz_o <= r_exc_dbz;
        if (r_exc_dbz || r_exc_ovf) begin
          r_quo_o <= sat_quotient();
          r_rem_o <= sat_remainder(r_exc_dbz, r_lo);
        end else begin
          r_quo_o <= {r_q[WIDTH-2:0], w_step_q};
          r_rem_o <= w_step_r[WIDTH-1:0];
        end
      end
    end
  end
endmodule
